// File: rtl/pulse_sched_pkg.sv
// rtl/pulse_sched_pkg.sv - shared types and constants for the pulse BRAM scheduler
//
// Holds the scheduler state encoding, the arbitration class encoding, the
// default template length and the word-to-byte address stride.
package pulse_sched_pkg;

  localparam int TPL_LEN_DEF = 50;
  localparam int BYTE_STRIDE = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INJ_RD   = 3'd1,
    ST_INJ_WAIT = 3'd2,
    ST_INJ_WR   = 3'd3,
    ST_DRN_RD   = 3'd4,
    ST_DRN_WAIT = 3'd5,
    ST_DRN_CLR  = 3'd6
  } sched_state_t;

  // Requester classes sharing the BRAM port.
  typedef enum logic {
    CLS_INJ   = 1'b0,
    CLS_DRAIN = 1'b1
  } arb_class_t;

endpackage

// File: rtl/fp32_adder.sv
// rtl/fp32_adder.sv - combinational IEEE-754 single-precision adder
//
// Ports:
//   a, b : 32-bit operands
//   y    : a + b, round-to-nearest-even
// Subnormal inputs are treated as zero and underflowing results flush to
// zero; an infinite/NaN operand of the larger magnitude is passed through.
module fp32_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  logic [31:0]       l_op;
  logic [31:0]       s_op;
  logic [7:0]        el;
  logic [7:0]        es;
  logic [23:0]       ml;
  logic [23:0]       ms;
  logic [7:0]        ediff;
  logic [26:0]       ml_x;
  logic [26:0]       ms_x;
  logic [26:0]       ms_sh;
  logic              sticky;
  logic [27:0]       sum;
  logic [4:0]        lz;
  logic [27:0]       norm_sh;
  logic              round_up;
  logic [24:0]       rnd;
  logic [22:0]       mant;
  logic signed [9:0] e_fin;

  always_comb begin
    // Order operands by magnitude so alignment only ever shifts the smaller one.
    if (a[30:0] >= b[30:0]) begin
      l_op = a;
      s_op = b;
    end else begin
      l_op = b;
      s_op = a;
    end
    el    = l_op[30:23];
    es    = s_op[30:23];
    ml    = (el == 8'd0) ? 24'd0 : {1'b1, l_op[22:0]};
    ms    = (es == 8'd0) ? 24'd0 : {1'b1, s_op[22:0]};
    ediff = el - es;
    ml_x  = {ml, 3'b000};
    ms_x  = {ms, 3'b000};

    // Three extra low bits carry guard/round, bit 0 also collects sticky.
    if (ediff > 8'd26) begin
      ms_sh  = 27'd0;
      sticky = |ms_x;
    end else begin
      ms_sh  = ms_x >> ediff;
      sticky = |(ms_x & ~({27{1'b1}} << ediff));
    end
    ms_sh[0] = ms_sh[0] | sticky;

    if (l_op[31] ^ s_op[31]) begin
      sum = {1'b0, ml_x} - {1'b0, ms_sh};
    end else begin
      sum = {1'b0, ml_x} + {1'b0, ms_sh};
    end

    lz = 5'd0;
    for (int k = 0; k < 28; k++) begin
      if (sum[k]) begin
        lz = 5'(27 - k);
      end
    end

    // Leading one lands on bit 27: [27:4] significand, [3] guard, [2:0] sticky.
    norm_sh  = sum << lz;
    round_up = norm_sh[3] & ((|norm_sh[2:0]) | norm_sh[4]);
    rnd      = {1'b0, norm_sh[27:4]} + {24'd0, round_up};
    mant     = rnd[24] ? rnd[23:1] : rnd[22:0];
    e_fin    = $signed({2'b00, el}) + 10'sd1 - $signed({5'b00000, lz})
             + $signed({9'd0, rnd[24]});

    if (el == 8'hFF) begin
      y = l_op;
    end else if (sum == 28'd0) begin
      y = 32'd0;
    end else if (e_fin <= 10'sd0) begin
      y = 32'd0;
    end else if (e_fin >= 10'sd255) begin
      y = {l_op[31], 8'hFF, 23'd0};
    end else begin
      y = {l_op[31], e_fin[7:0], mant};
    end
  end

endmodule

// File: rtl/pulse_base_fifo.sv
// rtl/pulse_base_fifo.sv - pending pulse base-index queue
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, din   : write din when accepted (not full, or popping this cycle)
//   pop         : retire the head entry (ignored when empty)
//   dout        : head entry, combinational from storage
//   full, empty : registered from the occupancy count
module pulse_base_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             pop_ok;
  logic             push_ok;
  logic [W-1:0]     mem_q [DEPTH];

  always_comb begin
    pop_ok   = pop & ~empty_q;
    // A push into a full queue is fine when the head leaves in the same cycle.
    push_ok  = push & (~full_q | pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == (PTR_W+1)'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: entries are only read behind the count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/pulse_rmw_sched.sv
// rtl/pulse_rmw_sched.sv - pulse BRAM read-modify-write sequencer and drain arbiter
//
// Queues pulse-injection requests and adds a TPL_LEN-word fp32 template into
// the accumulation BRAM at a circular base index, one word per RD/WAIT/WR
// triple. Shares the single BRAM port round-robin with a word readout (drain)
// requester; arbitration happens only in IDLE so a template is never split.
//
// Build option: define DRAIN_CLEAR_EN to zero each drained word (read-and-clear).
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   pulse_req, pulse_base    : injection strobe and start word index
//   q_full, drop_cnt         : queue full flag, saturating dropped-pulse count
//   busy                     : FSM active or injections pending
//   drain_req, drain_idx     : readout request (level) and word index
//   drain_ack, drain_data    : one-cycle ack with the word read
//   tpl_idx, tpl_data        : template ROM index and its combinational data
//   bram_addr_pulse          : byte address (word index * 4)
//   bram_data_in_pulse       : write data (0 when not writing)
//   bram_we_pulse, ena_pulse : BRAM write enable and port enable
//   bram_data_out_pulse      : BRAM read data, one cycle after an enabled read
module pulse_rmw_sched
  import pulse_sched_pkg::*;
#(
  parameter int TPL_LEN   = TPL_LEN_DEF,
  parameter int BUF_WORDS = 1024,
  parameter int IDX_W     = 10,
  parameter int Q_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse_req,
  input  logic [IDX_W-1:0] pulse_base,
  output logic             q_full,
  output logic [15:0]      drop_cnt,
  output logic             busy,
  input  logic             drain_req,
  input  logic [IDX_W-1:0] drain_idx,
  output logic             drain_ack,
  output logic [31:0]      drain_data,
  output logic [5:0]       tpl_idx,
  input  logic [31:0]      tpl_data,
  output logic [31:0]      bram_addr_pulse,
  output logic [31:0]      bram_data_in_pulse,
  output logic             bram_we_pulse,
  output logic             ena_pulse,
  input  logic [31:0]      bram_data_out_pulse
);

  sched_state_t     state_q, state_d;
  arb_class_t       rr_last_q, rr_last_d;
  logic [5:0]       i_q, i_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic             drain_ack_q, drain_ack_d;
  logic [31:0]      drain_data_q, drain_data_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [IDX_W-1:0] head_base;
  logic             pop;
  logic             push_ok;
  logic             inj_pend;
  logic             drn_pend;
  logic [IDX_W-1:0] inj_idx;
  logic [IDX_W-1:0] addr_idx;
  logic [31:0]      add_sum;

  pulse_base_fifo #(
    .DEPTH (Q_DEPTH),
    .W     (IDX_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_ok),
    .din   (pulse_base),
    .pop   (pop),
    .dout  (head_base),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  fp32_adder u_add (
    .a (bram_data_out_pulse),
    .b (tpl_data),
    .y (add_sum)
  );

  // The head entry stays in the queue for the whole template, so its base
  // is read directly; IDX_W-bit addition wraps at BUF_WORDS.
  assign inj_idx = head_base + IDX_W'(i_q);

  // While the ack is up the requester has not yet dropped drain_req; ignore it.
  assign drn_pend = drain_req & ~drain_ack_q;
  assign inj_pend = ~fifo_empty;

  always_comb begin
    state_d            = state_q;
    rr_last_d          = rr_last_q;
    i_d                = i_q;
    drain_ack_d        = 1'b0;
    drain_data_d       = drain_data_q;
    pop                = 1'b0;
    ena_pulse          = 1'b0;
    bram_we_pulse      = 1'b0;
    bram_data_in_pulse = 32'd0;
    addr_idx           = '0;

    case (state_q)
      ST_IDLE: begin
        if (inj_pend && (!drn_pend || rr_last_q == CLS_DRAIN)) begin
          state_d   = ST_INJ_RD;
          rr_last_d = CLS_INJ;
          i_d       = 6'd0;
        end else if (drn_pend) begin
          state_d   = ST_DRN_RD;
          rr_last_d = CLS_DRAIN;
        end
      end
      ST_INJ_RD: begin
        ena_pulse = 1'b1;
        addr_idx  = inj_idx;
        state_d   = ST_INJ_WAIT;
      end
      ST_INJ_WAIT: begin
        addr_idx = inj_idx;
        state_d  = ST_INJ_WR;
      end
      ST_INJ_WR: begin
        ena_pulse          = 1'b1;
        bram_we_pulse      = 1'b1;
        addr_idx           = inj_idx;
        bram_data_in_pulse = add_sum;
        if (i_q == 6'(TPL_LEN - 1)) begin
          // i_q is left at the last sample so tpl_idx holds while idle.
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else begin
          i_d     = i_q + 6'd1;
          state_d = ST_INJ_RD;
        end
      end
      ST_DRN_RD: begin
        ena_pulse = 1'b1;
        addr_idx  = drain_idx;
        state_d   = ST_DRN_WAIT;
      end
      ST_DRN_WAIT: begin
        addr_idx     = drain_idx;
        drain_data_d = bram_data_out_pulse;
        drain_ack_d  = 1'b1;
`ifdef DRAIN_CLEAR_EN
        state_d      = ST_DRN_CLR;
`else
        state_d      = ST_IDLE;
`endif
      end
`ifdef DRAIN_CLEAR_EN
      ST_DRN_CLR: begin
        ena_pulse     = 1'b1;
        bram_we_pulse = 1'b1;
        addr_idx      = drain_idx;
        state_d       = ST_IDLE;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Queue admission and dropped-pulse accounting.
  always_comb begin
    push_ok    = pulse_req & (~fifo_full | pop);
    drop_cnt_d = drop_cnt_q;
    if (pulse_req && !push_ok && drop_cnt_q != 16'hFFFF) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rr_last_q    <= CLS_DRAIN;
      i_q          <= 6'd0;
      drop_cnt_q   <= 16'd0;
      drain_ack_q  <= 1'b0;
      drain_data_q <= 32'd0;
    end else begin
      state_q      <= state_d;
      rr_last_q    <= rr_last_d;
      i_q          <= i_d;
      drop_cnt_q   <= drop_cnt_d;
      drain_ack_q  <= drain_ack_d;
      drain_data_q <= drain_data_d;
    end
  end

  // Outside IDLE only the issuing states place an address on the port.
  assign bram_addr_pulse = ena_pulse ? 32'(addr_idx) * BYTE_STRIDE : 32'd0;
  assign tpl_idx         = i_q;
  assign q_full          = fifo_full;
  assign drop_cnt        = drop_cnt_q;
  assign busy            = (state_q != ST_IDLE) | ~fifo_empty;
  assign drain_ack       = drain_ack_q;
  assign drain_data      = drain_data_q;

endmodule
